// File: rtl/imem_loader_if.sv
// Instruction-image stream into the program loader.
// The source (test harness or host) drives the word, its valid flag and the
// end-of-image marker. The loader returns ready.
interface imem_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader for the simulated MIPS system.
// Streams instruction words into imem at consecutive word addresses from
// BASE_ADDR, and holds the processor in reset until the image is in place.
// Optional macro IMEM_LOADER_VERIFY_EN adds a read-back pass. This pass
// compares the sum of the stored words against the sum of the streamed words
// before the processor is released.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start, stream ignored
// ST_LOAD   | accepting words, one registered write per accepted beat
// ST_FLUSH  | last write in flight, stream closed
// ST_VERIFY | read-back and sum compare (IMEM_LOADER_VERIFY_EN only)
// ST_DONE   | image in place, cpu released; left only by reset
// ST_ERROR  | overflow or verify mismatch, cpu held; left only by reset
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        s,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_din,
    input  logic [31:0]         mem_dout,
    output logic [1:0]          mem_access_sz,
    output logic                mem_rd_wr,
    output logic                mem_en,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output logic [15:0]         word_count
);

    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_rd_wr_q, mem_rd_wr_d;
    logic [15:0] word_count_q, word_count_d;

    logic        beat;
    logic        at_cap;
    logic        s_ready_o;

    // A beat is only taken in LOAD, so start+valid in IDLE never writes.
    assign beat   = (state_q == ST_LOAD) && s.s_valid;
    assign at_cap = (word_count_q == 16'(MAX_WORDS - 1));

`ifdef IMEM_LOADER_VERIFY_EN
    logic [31:0] checksum_q, checksum_d;
    logic [31:0] vsum_q, vsum_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] rcv_cnt_q, rcv_cnt_d;
    logic        verify_end;
    logic        sum_ok;

    // Data returns one cycle behind each read, so rcv_cnt reaching the word
    // count means every issued read has come back.
    assign verify_end = (rcv_cnt_q == word_count_q);
    assign sum_ok     = (vsum_q == checksum_q);
`else
    logic unused_mem_dout;
    assign unused_mem_dout = ^mem_dout;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (s.s_last) begin
                        state_d = ST_FLUSH;
                    end else if (at_cap) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_FLUSH: begin
`ifdef IMEM_LOADER_VERIFY_EN
                state_d = ST_VERIFY;
`else
                state_d = ST_DONE;
`endif
            end
            ST_VERIFY: begin
`ifdef IMEM_LOADER_VERIFY_EN
                if (verify_end) begin
                    state_d = sum_ok ? ST_DONE : ST_ERROR;
                end
`else
                state_d = ST_ERROR;
`endif
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready_o = (state_q == ST_LOAD);
        done      = (state_q == ST_DONE);
        error     = (state_q == ST_ERROR);
        cpu_reset = (state_q != ST_DONE);
    end

    assign s.s_ready = s_ready_o;

    // Memory port, word counter and checksums
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_en_d     = 1'b0;
        mem_rd_wr_d  = 1'b1;
        word_count_d = word_count_q;
`ifdef IMEM_LOADER_VERIFY_EN
        checksum_d   = checksum_q;
        vsum_d       = vsum_q;
        rd_cnt_d     = rd_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
`endif
        if (beat) begin
            mem_addr_d   = BASE_ADDR + {14'd0, word_count_q, 2'b00};
            mem_din_d    = s.s_data;
            mem_en_d     = 1'b1;
            mem_rd_wr_d  = 1'b0;
            word_count_d = word_count_q + 16'd1;
`ifdef IMEM_LOADER_VERIFY_EN
            checksum_d   = checksum_q + s.s_data;
`endif
        end
`ifdef IMEM_LOADER_VERIFY_EN
        // The first read is issued from FLUSH so that read-back starts on the
        // same edge that enters VERIFY.
        if (((state_q == ST_FLUSH) || (state_q == ST_VERIFY)) &&
            (rd_cnt_q != word_count_q)) begin
            mem_addr_d  = BASE_ADDR + {14'd0, rd_cnt_q, 2'b00};
            mem_en_d    = 1'b1;
            mem_rd_wr_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 16'd1;
        end
        if (mem_en_q && mem_rd_wr_q) begin
            vsum_d    = vsum_q + mem_dout;
            rcv_cnt_d = rcv_cnt_q + 16'd1;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q   <= BASE_ADDR;
            mem_din_q    <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_rd_wr_q  <= 1'b1;
            word_count_q <= 16'd0;
`ifdef IMEM_LOADER_VERIFY_EN
            checksum_q   <= 32'd0;
            vsum_q       <= 32'd0;
            rd_cnt_q     <= 16'd0;
            rcv_cnt_q    <= 16'd0;
`endif
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_en_q     <= mem_en_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            word_count_q <= word_count_d;
`ifdef IMEM_LOADER_VERIFY_EN
            checksum_q   <= checksum_d;
            vsum_q       <= vsum_d;
            rd_cnt_q     <= rd_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
`endif
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_din       = mem_din_q;
    assign mem_en        = mem_en_q;
    assign mem_rd_wr     = mem_rd_wr_q;
    assign mem_access_sz = SZ_WORD;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-capacity loader (dut) and a
// four-word loader (dut2) for the overflow case, each with a small word memory.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clk;
    logic        reset;
    logic        start, start2;
    logic        mem_clr, corrupt;

    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_access_sz;
    logic        mem_rd_wr, mem_en, cpu_reset, done, error;
    logic [15:0] word_count;

    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic [1:0]  mem_access_sz2;
    logic        mem_rd_wr2, mem_en2, cpu_reset2, done2, error2;
    logic [15:0] word_count2;

    logic [31:0] mem1 [0:15];
    logic [31:0] mem2 [0:15];
    logic [31:0] img  [0:4];

    int n_checks;
    int n_fail;

    imem_loader_if s1 ();
    imem_loader_if s2 ();

    imem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .s             (s1),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_access_sz (mem_access_sz),
        .mem_rd_wr     (mem_rd_wr),
        .mem_en        (mem_en),
        .cpu_reset     (cpu_reset),
        .done          (done),
        .error         (error),
        .word_count    (word_count)
    );

    imem_loader #(.MAX_WORDS(4)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .start         (start2),
        .s             (s2),
        .mem_addr      (mem_addr2),
        .mem_din       (mem_din2),
        .mem_dout      (mem_dout2),
        .mem_access_sz (mem_access_sz2),
        .mem_rd_wr     (mem_rd_wr2),
        .mem_en        (mem_en2),
        .cpu_reset     (cpu_reset2),
        .done          (done2),
        .error         (error2),
        .word_count    (word_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memories: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 32'd0;
                mem2[i] <= 32'd0;
            end
        end else begin
            if (mem_en && !mem_rd_wr) mem1[mem_addr[5:2]] <= mem_din;
            if (corrupt) mem1[2] <= 32'd0;
            if (mem_en2 && !mem_rd_wr2) mem2[mem_addr2[5:2]] <= mem_din2;
        end
    end

    assign mem_dout  = mem1[mem_addr[5:2]];
    assign mem_dout2 = mem2[mem_addr2[5:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_s_ready"},   32'(s1.s_ready), 32'd0);
        check({tag, "_mem_en"},    32'(mem_en),     32'd0);
        check({tag, "_mem_rd_wr"}, 32'(mem_rd_wr),  32'd1);
        check({tag, "_mem_addr"},  mem_addr,        BASE);
        check({tag, "_mem_din"},   mem_din,         32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset),  32'd1);
        check({tag, "_done"},      32'(done),       32'd0);
        check({tag, "_error"},     32'(error),      32'd0);
        check({tag, "_wc"},        32'(word_count), 32'd0);
    endtask

    // Called in the FLUSH cycle after the last beat of a four-word image.
    task automatic finish_image(input string tag, input logic expect_ok);
`ifdef IMEM_LOADER_VERIFY_EN
        for (int i = 0; i < 4; i++) begin
            step();
            check({tag, "_vrd_en"},   32'(mem_en),    32'd1);
            check({tag, "_vrd_rw"},   32'(mem_rd_wr), 32'd1);
            check({tag, "_vrd_addr"}, mem_addr,       BASE + 32'(4 * i));
            check({tag, "_vrd_cpu"},  32'(cpu_reset), 32'd1);
        end
        step();
        check({tag, "_vcmp_en"},   32'(mem_en), 32'd0);
        check({tag, "_vcmp_done"}, 32'(done),   32'd0);
        step();
        check({tag, "_fin_done"},  32'(done),      32'(expect_ok));
        check({tag, "_fin_error"}, 32'(error),     32'(!expect_ok));
        check({tag, "_fin_cpu"},   32'(cpu_reset), 32'(!expect_ok));
`else
        step();
        check({tag, "_fin_done"},  32'(done),       32'(expect_ok));
        check({tag, "_fin_cpu"},   32'(cpu_reset),  32'd0);
        check({tag, "_fin_error"}, 32'(error),      32'd0);
        check({tag, "_fin_en"},    32'(mem_en),     32'd0);
        check({tag, "_fin_ready"}, 32'(s1.s_ready), 32'd0);
`endif
    endtask

    task automatic beat1(input string tag, input int i, input logic last);
        s1.s_valid = 1'b1;
        s1.s_data  = img[i];
        s1.s_last  = last;
        step();
        check({tag, "_wr_en"},   32'(mem_en),     32'd1);
        check({tag, "_wr_rw"},   32'(mem_rd_wr),  32'd0);
        check({tag, "_wr_addr"}, mem_addr,        BASE + 32'(4 * i));
        check({tag, "_wr_din"},  mem_din,         img[i]);
        check({tag, "_wr_wc"},   32'(word_count), 32'(i + 1));
    endtask

    task automatic chk_image(input string tag);
        for (int i = 0; i < 4; i++) check({tag, "_mem"}, mem1[i], img[i]);
        check({tag, "_wc"}, 32'(word_count), 32'd4);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        img[0] = 32'h2008_0005;
        img[1] = 32'h2009_0007;
        img[2] = 32'h0109_5020;
        img[3] = 32'h0000_000C;
        img[4] = 32'hDEAD_BEEF;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        mem_clr = 1'b1; corrupt = 1'b0;
        s1.s_valid = 1'b0; s1.s_data = 32'd0; s1.s_last = 1'b0;
        s2.s_valid = 1'b0; s2.s_data = 32'd0; s2.s_last = 1'b0;
        step();
        step();

        // Reset state
        chk_reset("rst");
        check("rst_sz", 32'(mem_access_sz), 32'd2);
        check("rst2_ready", 32'(s2.s_ready), 32'd0);
        reset = 1'b0; mem_clr = 1'b0;

        // Back-to-back image
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_ready", 32'(s1.s_ready), 32'd1);
        check("t1_cpu",   32'(cpu_reset),  32'd1);
        for (int i = 0; i < 4; i++) beat1("t1", i, i == 3);
        s1.s_valid = 1'b0; s1.s_last = 1'b0;
        check("t1_flush_ready", 32'(s1.s_ready), 32'd0);
        check("t1_flush_done",  32'(done),       32'd0);
        check("t1_flush_cpu",   32'(cpu_reset),  32'd1);
        finish_image("t1", 1'b1);
        chk_image("t1");

        // start held in DONE
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check("t6_done",  32'(done),       32'd1);
        check("t6_wc",    32'(word_count), 32'd4);
        check("t6_ready", 32'(s1.s_ready), 32'd0);
        check("t6_en",    32'(mem_en),     32'd0);

        // Image with a three-cycle gap
        reset = 1'b1; mem_clr = 1'b1;
        step();
        reset = 1'b0; mem_clr = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        beat1("t2", 0, 1'b0);
        beat1("t2", 1, 1'b0);
        s1.s_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            step();
            check("t2_gap_en",    32'(mem_en),     32'd0);
            check("t2_gap_ready", 32'(s1.s_ready), 32'd1);
            check("t2_gap_wc",    32'(word_count), 32'd2);
        end
        beat1("t2", 2, 1'b0);
        beat1("t2", 3, 1'b1);
        s1.s_valid = 1'b0; s1.s_last = 1'b0;
        finish_image("t2", 1'b1);
        chk_image("t2");

        // Overflow on the four-word loader
        reset = 1'b1; mem_clr = 1'b1;
        step();
        reset = 1'b0; mem_clr = 1'b0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        s2.s_valid = 1'b1; s2.s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s2.s_data = img[i];
            step();
            check("t3_wr_en",   32'(mem_en2), 32'd1);
            check("t3_wr_addr", mem_addr2,    BASE + 32'(4 * i));
            check("t3_wr_din",  mem_din2,     img[i]);
        end
        check("t3_error", 32'(error2),      32'd1);
        check("t3_cpu",   32'(cpu_reset2),  32'd1);
        check("t3_ready", 32'(s2.s_ready),  32'd0);
        check("t3_done",  32'(done2),       32'd0);
        check("t3_wc",    32'(word_count2), 32'd4);
        s2.s_data = img[4];
        repeat (2) begin
            step();
            check("t3_hold_en",    32'(mem_en2),     32'd0);
            check("t3_hold_error", 32'(error2),      32'd1);
            check("t3_hold_wc",    32'(word_count2), 32'd4);
        end
        s2.s_valid = 1'b0;
        check("t3_mem3", mem2[3], img[3]);
        check("t3_mem4", mem2[4], 32'd0);

        // Reset two cycles after the first beat, then reload
        reset = 1'b1; mem_clr = 1'b1;
        step();
        reset = 1'b0; mem_clr = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        s1.s_valid = 1'b1; s1.s_data = img[0];
        step();
        s1.s_data = img[1];
        step();
        s1.s_data = img[2];
        reset = 1'b1;
        step();
        reset = 1'b0;
        s1.s_valid = 1'b0;
        chk_reset("t4");
        check("t4_mem0", mem1[0], img[0]);
        check("t4_mem1", mem1[1], img[1]);
        check("t4_mem2", mem1[2], 32'd0);
        // start with a simultaneous valid beat in IDLE
        start = 1'b1; s1.s_valid = 1'b1; s1.s_data = 32'h1234_5678;
        check("t4_idle_ready", 32'(s1.s_ready), 32'd0);
        step();
        start = 1'b0; s1.s_valid = 1'b0;
        check("t4_start_en",    32'(mem_en),     32'd0);
        check("t4_start_wc",    32'(word_count), 32'd0);
        check("t4_start_ready", 32'(s1.s_ready), 32'd1);
        for (int i = 0; i < 4; i++) beat1("t4", i, i == 3);
        s1.s_valid = 1'b0; s1.s_last = 1'b0;
        finish_image("t4", 1'b1);
        chk_image("t4");

`ifdef IMEM_LOADER_VERIFY_EN
        // Corrupted word caught by read-back
        reset = 1'b1; mem_clr = 1'b1;
        step();
        reset = 1'b0; mem_clr = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) beat1("t5", i, i == 3);
        s1.s_valid = 1'b0; s1.s_last = 1'b0;
        corrupt = 1'b1;
        finish_image("t5", 1'b0);
        corrupt = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the simulated MIPS system: the writer side of the instruction-memory port. It accepts a stream of 32-bit instruction words and writes them into `memory` at consecutive word addresses from `base_addr`. While loading, it holds the processor in reset; it releases reset once the image is written and, optionally, checksum-verified. It sits between the test harness (or host stream) and the imem instance, in front of `mips`.

## Interface
- `base_addr`, default 32'h8002_0000: address of the first word; equals the processor's `pc_init`.
- `max_words`, default 1024: image capacity in words.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  32  instruction word.
- `s_last`  in  1  marks final word of the image.
- `s_ready`  out  1  loader accepts a word this cycle.
- `mem_addr`  out  32  memory address.
- `mem_din`  out  32  write data; connects to memory `data_in`.
- `mem_dout`  in  32  read data from memory `data_out`.
- `mem_access_sz`  out  2  constant `sz_word` (2'b10).
- `mem_rd_wr`  out  1  1 = read, 0 = write.
- `mem_en`  out  1  memory enable.
- `cpu_reset`  out  1  reset to `mips`; high until load completes.
- `done`  out  1  image loaded (and verified, if enabled).
- `error`  out  1  overflow or verify mismatch; sticky.
- `word_count`  out  16  words written so far.

## Operation
- States: IDLE, LOAD, FLUSH, VERIFY (macro only), DONE, ERROR.
- **Reset values:**
  - `s_ready` = 0, `mem_en` = 0, `mem_rd_wr` = 1.
  - `mem_addr` = `base_addr`, `mem_din` = 0.
  - `cpu_reset` = 1, `done` = 0, `error` = 0, `word_count` = 0, checksum = 0.
- **IDLE:**
  - `start` moves to LOAD.
  - `s_valid` is ignored.
- **LOAD:**
  - `s_ready` = 1.
  - Each accepted beat (`s_valid & s_ready`) registers a write:
    - `mem_addr` = `base_addr` + 4×`word_count`
    - `mem_din` = `s_data`
    - `mem_en` = 1, `mem_rd_wr` = 0
  - The same beat increments `word_count` and adds `s_data` into a 32-bit checksum (modulo 2^32).
  - In cycles with no accepted beat, `mem_en` = 0.
- **End of image:**
  - Accepted beat with `s_last` moves to FLUSH. That beat's write is still issued.
  - Accepted beat without `s_last` when `word_count` = `max_words`−1 moves to ERROR. That beat's write is still issued.
- **FLUSH:**
  - One cycle, `s_ready` = 0.
  - Moves to VERIFY if enabled, else DONE.
- **DONE:**
  - `done` = 1, `cpu_reset` = 0, `mem_en` = 0, `s_ready` = 0.
  - `start` is ignored.
- **ERROR:**
  - `error` = 1, `cpu_reset` = 1, `s_ready` = 0, `mem_en` = 0.
- Only `reset` leaves DONE or ERROR.
- Reset mid-LOAD or mid-VERIFY returns all state to reset values in the next cycle. No further writes are issued; memory keeps its partial contents.
- `start` and `s_valid` asserted in the same cycle in IDLE: only `start` takes effect. The beat is not accepted (`s_ready` = 0).

## Timing
- `start` sampled at edge 0 → LOAD during cycle 1, `s_ready` = 1 in cycle 1.
- Throughput is one word per cycle. Write latency is one cycle: a beat accepted at edge t drives the write during cycle t+1, committed at edge t+1.
- Last beat accepted at edge t → write in cycle t+1, FLUSH in cycle t+1 → DONE, `cpu_reset` = 0 from cycle t+2 (without macro).
- Memory read latency is one cycle: address presented at edge n, `mem_dout` valid for sampling at edge n+1.

## Configuration
- `IMEM_LOADER_VERIFY_EN` defined:
  - After FLUSH, VERIFY issues N reads (`mem_rd_wr` = 1, `mem_en` = 1) at `base_addr`…`base_addr`+4(N−1), one per cycle. N is the number of words loaded.
  - It sums the returned words.
  - One cycle after the last data returns, it compares the read-back sum against the load checksum:
    - equal → DONE
    - unequal → ERROR
  - From a FLUSH at cycle t+1, `done` rises at cycle t+N+3.
  - `cpu_reset` stays 1 throughout VERIFY.
- Undefined: no VERIFY state; FLUSH goes directly to DONE. Checksum logic may be removed.

## Test plan
- Reset, pulse `start`, stream 4 words 0x20080005, 0x20090007, 0x01095020, 0x0000000C back-to-back with `s_last` on the 4th → writes at 0x80020000/04/08/0C on consecutive cycles; `done` = 1 and `cpu_reset` = 0 two cycles after the last beat; `word_count` = 4.
- Same image with `s_valid` dropped for 3 cycles mid-stream → `mem_en` = 0 in the gap cycles, identical memory contents, `word_count` = 4.
- `max_words` = 4, stream 5 words, no `s_last` by word 4 → 4th write issued, then `error` = 1, `cpu_reset` = 1, `s_ready` = 0; 5th word never accepted.
- Assert `reset` two cycles after the first beat → next cycle all outputs at reset values; only the first 1–2 words are written; a new `start` reloads from 0x80020000.
- With `IMEM_LOADER_VERIFY_EN`, load 4 words → 4 reads follow, then `done`. Force memory word 0x80020008 to 0 during VERIFY → `error` = 1, `done` = 0.
- `start` held in DONE → no state change, `word_count` unchanged.
